unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Arbiter and sequencer that shares one single-port unified memory between the pipeline's instruction fetch (IF stage) and the load/store port (MEM stage). Each requester holds a request until it is served. The arbiter latches the winning request, drives the memory through a variable-latency ready handshake and returns read data with a one-cycle done pulse. It also produces the stall signals consumed by the hazard/PC-write logic. Data accesses win by default; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  ADDR_W  fetch address
- if_abort  in  1  cancel pending/in-flight fetch (branch flush)
- if_rdata  out  DATA_W  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata stable until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  d_req & ~d_done (combinational)
- mem_req  out  1  memory access active
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  access complete this cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, IBUSY, DBUSY, IRESP, DRESP.
- Arbitration happens only in IDLE:
  - d_req & (~if_req | starve_cnt < STARVE_LIMIT) → DBUSY.
  - Otherwise, if_req & ~if_abort → IBUSY.
  - Otherwise stay in IDLE.
  - On grant, latch addr, wdata and we into the mem_* registers. For a fetch, we=0 and wdata=0.
- IBUSY/DBUSY: mem_req=1 with latched values. On mem_ready, capture mem_rdata into the respective rdata register and go to IRESP/DRESP. mem_wdata is held unchanged for the whole access.
- IRESP: if_done=1 unless the abort flag is set, then IDLE. DRESP: d_done=1, then IDLE.
- Stores return d_rdata = 0.
- starve_cnt:
  - +1 on each data grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on an instruction grant, and in IDLE whenever if_req=0.
  - Width $clog2(STARVE_LIMIT+1).
- if_abort:
  - In IDLE: the fetch is not granted.
  - In IBUSY: the access finishes on the memory, a sticky abort flag is set, and if_done is suppressed in IRESP. The flag clears on leaving IRESP.
  - In IRESP: suppresses if_done that cycle.
  - Data transactions are never aborted.
- A requester may keep req high in the done cycle with new operands to issue back-to-back. Arbitration re-samples the request in the following IDLE.

## Timing
- Reset values: state=IDLE; mem_req, mem_we, if_done, d_done, busy, starve_cnt = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Reset mid-transaction drops mem_req immediately. The memory must tolerate this, and no done pulse is issued.
- Outputs are Moore-decoded from registered state.
- Latency: request seen in IDLE at cycle 0 → mem_req from cycle 1 → mem_ready at cycle k≥1 → done at cycle k+1.
- Zero-wait memory: 2 cycles request-to-done, one transaction per 3 cycles.
- Simultaneous if_req and d_req in IDLE with starve_cnt<STARVE_LIMIT: data wins.
- Simultaneous mem_ready and if_abort in IBUSY: the abort flag is still set and if_done is suppressed.
- mem_ready outside IBUSY/DBUSY is ignored.

## Structure
- Shared package (pipeline package): state enum arb_state_t with the five encodings, and defaults for ADDR_W/DATA_W.
- One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and an at_limit output.
- Everything else stays in unified_mem_arbiter.

## Test plan
- Single fetch, if_addr=0x10, mem_ready one cycle after mem_req, mem_rdata=0x00500093 → if_done at cycle 3, if_rdata=0x00500093, stall_if high cycles 0–2.
- if_req and d_req (load 0x40) both high continuously, STARVE_LIMIT=4, zero-wait → grant order D,D,D,D,I,D…; no fetch waits more than 4 data transactions.
- Store d_addr=0x80, d_wdata=0xDEADBEEF, mem_ready after 5 wait cycles → mem_we=1 and mem_wdata stable for all 6 mem_req cycles; d_done one cycle after ready; d_rdata=0.
- if_abort pulsed in the second cycle of IBUSY → access completes on the memory, if_done never asserts, next data request is granted from IDLE.
- Reset asserted mid-DBUSY → mem_req, busy and done drop asynchronously; after release, state is IDLE and the first request is served normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Holds the sequencer state encoding and default bus widths.
package unified_mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IBUSY = 3'd1,
    DBUSY = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of data grants issued while a fetch is waiting.
// at_limit tells the arbiter that the fetch must be served next.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // Clear has priority so an instruction grant always restarts the window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT_VAL);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins by default; a starvation counter guarantees fetch progress.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t state, next_state;

  logic grant_d;
  logic grant_i;
  logic starve_inc;
  logic starve_clr;
  logic at_limit;
  logic abort_flag;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Arbitration only happens in IDLE; busy states wait for the memory handshake
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state)
      IDLE: begin
        if (!if_req) begin
          starve_clr = 1'b1;
        end
        if (d_req && (!if_req || !at_limit)) begin
          grant_d    = 1'b1;
          starve_inc = if_req;
          next_state = DBUSY;
        end else if (if_req && !if_abort) begin
          grant_i    = 1'b1;
          starve_clr = 1'b1;
          next_state = IBUSY;
        end
      end
      IBUSY: if (mem_ready) next_state = IRESP;
      DBUSY: if (mem_ready) next_state = DRESP;
      IRESP: next_state = IDLE;
      DRESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // An aborted fetch still completes on the memory; only its done pulse is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      abort_flag <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_we    <= d_we;
      end else if (grant_i) begin
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_we    <= 1'b0;
      end
      if ((state == IBUSY) && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      if ((state == DBUSY) && mem_ready) begin
        d_rdata <= mem_we ? '0 : mem_rdata;
      end
      if ((state == IBUSY) && if_abort) begin
        abort_flag <= 1'b1;
      end else if (state == IRESP) begin
        abort_flag <= 1'b0;
      end
    end
  end

  assign mem_req   = (state == IBUSY) || (state == DBUSY);
  assign busy      = (state != IDLE);
  assign if_done   = (state == IRESP) && !abort_flag && !if_abort;
  assign d_done    = (state == DRESP);
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

endmodule
